md_phase_sequencer: RTL and testbench

//  Timestep sequencer for the MD simulator: owns the per-cell P/V BRAM port mux by granting

---
 rtl/md_phase_sequencer.sv | 168 ++++++++++++++++
 tb/tb_md_phase_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_phase_sequencer.sv
// Timestep sequencer: grants the per-cell P/V BRAM mux to phase1 or phase3 in turn, with GUARD-cycle drains,
// one buffer swap per step and an optional watchdog. Outputs are registered and decoded from the state being entered.
module md_phase_sequencer #(
  parameter int N_CELL  = 27,
  parameter int STEP_W  = 16,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] n_steps,
  input  logic              p1_done,
  input  logic [N_CELL-1:0] p3_done,
  output logic              phase1_ready,
  output logic              phase3_ready,
  output logic              double_buffer,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              sim_done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1_RUN   = 3'd1,
    P1_DRAIN = 3'd2,
    P3_RUN   = 3'd3,
    P3_DRAIN = 3'd4,
    SWAP     = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;

  localparam int CMAX  = (GUARD > TIMEOUT) ? GUARD : TIMEOUT;
  localparam int CNT_W = $clog2(CMAX + 2);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CELL-1:0]   latch_q, latch_d;
  logic [STEP_W-1:0]   nsteps_q, nsteps_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                dbuf_q, dbuf_d;
  logic                err_q, err_d;
  logic                p1_rdy_q, p1_rdy_d;
  logic                p3_rdy_q, p3_rdy_d;
  logic                busy_q, busy_d;
  logic                sim_done_q, sim_done_d;
  logic                all_done;
  logic                timeout_hit;

  assign all_done    = &(latch_q | p3_done);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    latch_d  = '0;
    nsteps_d = nsteps_q;
    step_d   = step_q;
    dbuf_d   = dbuf_q;
    err_d    = err_q;

    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          err_d = 1'b0;
          if (n_steps != '0) begin
            nsteps_d = n_steps;
            step_d   = '0;
            state_d  = P1_RUN;
          end else begin
            state_d  = DONE;
          end
        end
      end
      P1_RUN: begin
        // a done arriving on the expiry cycle is checked first, so it wins
        if (p1_done)          state_d = (GUARD > 0) ? P1_DRAIN : P3_RUN;
        else if (timeout_hit) state_d = ERROR;
      end
      P1_DRAIN: begin
        if (cnt_q == GUARD_LAST) state_d = P3_RUN;
      end
      P3_RUN: begin
        if (all_done)         state_d = (GUARD > 0) ? P3_DRAIN : SWAP;
        else if (timeout_hit) state_d = ERROR;
        else                  latch_d = latch_q | p3_done;
      end
      P3_DRAIN: begin
        if (cnt_q == GUARD_LAST) state_d = SWAP;
      end
      SWAP: begin
        state_d = (step_q == nsteps_q) ? DONE : P1_RUN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort overrides every event, including a start seen in IDLE/ERROR
    if (abort) begin
      state_d  = IDLE;
      nsteps_d = nsteps_q;
      step_d   = step_q;
      err_d    = err_q;
      latch_d  = '0;
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    if (state_d == SWAP) begin
      dbuf_d = ~dbuf_q;
      step_d = step_q + STEP_W'(1);
    end

    if (state_d == ERROR) err_d = 1'b1;

    p1_rdy_d   = (state_d == P1_RUN);
    p3_rdy_d   = (state_d == P3_RUN);
    busy_d     = (state_d != IDLE) && (state_d != ERROR);
    sim_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      latch_q    <= '0;
      nsteps_q   <= '0;
      step_q     <= '0;
      dbuf_q     <= 1'b0;
      err_q      <= 1'b0;
      p1_rdy_q   <= 1'b0;
      p3_rdy_q   <= 1'b0;
      busy_q     <= 1'b0;
      sim_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      nsteps_q   <= nsteps_d;
      step_q     <= step_d;
      dbuf_q     <= dbuf_d;
      err_q      <= err_d;
      p1_rdy_q   <= p1_rdy_d;
      p3_rdy_q   <= p3_rdy_d;
      busy_q     <= busy_d;
      sim_done_q <= sim_done_d;
    end
  end

  assign phase1_ready  = p1_rdy_q;
  assign phase3_ready  = p3_rdy_q;
  assign double_buffer = dbuf_q;
  assign step_count    = step_q;
  assign busy          = busy_q;
  assign sim_done      = sim_done_q;
  assign err           = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_md_phase_sequencer.sv
// Bench for md_phase_sequencer: builds an expected per-cycle timeline of phases from randomized
// done delays, drives the phase handshakes from that timeline and checks every output each cycle.
module tb_md_phase_sequencer;

  localparam int N_CELL  = 27;
  localparam int STEP_W  = 16;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 16;

  localparam logic [2:0] S_IDLE = 3'd0, S_P1 = 3'd1, S_P1D = 3'd2, S_P3 = 3'd3,
                         S_P3D  = 3'd4, S_SWAP = 3'd5, S_DONE = 3'd6, S_ERR = 3'd7;

  logic              clk = 1'b0;
  logic              reset, start, abort, p1_done;
  logic [STEP_W-1:0] n_steps;
  logic [N_CELL-1:0] p3_done;
  logic              phase1_ready, phase3_ready, double_buffer, busy, sim_done, err;
  logic [STEP_W-1:0] step_count;
  logic [2:0]        state_dbg;

  md_phase_sequencer #(
    .N_CELL(N_CELL), .STEP_W(STEP_W), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .n_steps(n_steps),
    .p1_done(p1_done), .p3_done(p3_done), .phase1_ready(phase1_ready),
    .phase3_ready(phase3_ready), .double_buffer(double_buffer), .step_count(step_count),
    .busy(busy), .sim_done(sim_done), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // One timeline entry: the phase the sequencer should be in during a cycle,
  // and the inputs the bench presents during that same cycle.
  typedef struct {
    logic [2:0]        st;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] n;
    logic              p1;
    logic [N_CELL-1:0] p3;
  } ent_t;

  ent_t              plan[$];
  int                n_chk  = 0;
  int                n_fail = 0;
  logic              m_db   = 1'b0;
  logic [STEP_W-1:0] m_steps = '0;
  logic              m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [2:0] st);
    chk("state_dbg",     32'(state_dbg),     32'(st));
    chk("phase1_ready",  32'(phase1_ready),  32'(st == S_P1));
    chk("phase3_ready",  32'(phase3_ready),  32'(st == S_P3));
    chk("busy",          32'(busy),          32'(st != S_IDLE && st != S_ERR));
    chk("sim_done",      32'(sim_done),      32'(st == S_DONE));
    chk("double_buffer", 32'(double_buffer), 32'(m_db));
    chk("step_count",    32'(step_count),    32'(m_steps));
    chk("err",           32'(err),           32'(m_err));
    chk("grant_excl",    32'(phase1_ready & phase3_ready), 32'd0);
  endtask

  task automatic add(input logic [2:0] st, input logic s, input logic a,
                     input logic [STEP_W-1:0] n, input logic p1, input logic [N_CELL-1:0] p3);
    ent_t e;
    e.st = st; e.start = s; e.abort = a; e.n = n; e.p1 = p1; e.p3 = p3;
    plan.push_back(e);
  endtask

  task automatic add_drain(input logic [2:0] st);
    for (int i = 0; i < GUARD; i++) add(st, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  function automatic int rnd_dly();
    return int'($urandom_range(TIMEOUT, 1));
  endfunction

  // Each cell's done bit pulses once at some cycle of the phase; the last one completes it.
  task automatic add_p3(input int d3, input bit split, input bit ab);
    int                pa[N_CELL];
    logic [N_CELL-1:0] v;
    for (int b = 0; b < N_CELL; b++)
      pa[b] = split ? ((b < 14) ? 0 : d3 - 1) : int'($urandom_range(d3 - 1, 0));
    if (!split) pa[int'($urandom_range(N_CELL - 1, 0))] = d3 - 1;
    for (int c = 0; c < d3; c++) begin
      v = '0;
      for (int b = 0; b < N_CELL; b++) if (pa[b] == c) v[b] = 1'b1;
      add(S_P3, 1'b0, (c == d3 - 1) && ab, '0, 1'b0, v);
    end
  endtask

  task automatic add_run(input int nst, input logic [2:0] from_st, input int dly,
                         input int ab_step, input int ab_ph, input bit split);
    int d;
    add(from_st, 1'b1, 1'b0, STEP_W'(nst), 1'b0, '0);
    if (nst == 0) begin
      add(S_DONE, 1'b0, 1'b0, '0, 1'b0, '0);
      add(S_IDLE, 1'b0, 1'b0, '0, 1'b0, '0);
      return;
    end
    for (int s = 0; s < nst; s++) begin
      d = (dly > 0) ? dly : rnd_dly();
      for (int c = 0; c < d; c++)
        add(S_P1, 1'b0, (c == d - 1) && (s == ab_step) && (ab_ph == 1), '0, c == d - 1, '0);
      if (s == ab_step && ab_ph == 1) begin
        add(S_IDLE, 1'b0, 1'b0, '0, 1'b0, '0);
        return;
      end
      add_drain(S_P1D);
      d = (split && s == 0) ? 6 : ((dly > 0) ? dly : rnd_dly());
      add_p3(d, split && s == 0, (s == ab_step) && (ab_ph == 3));
      if (s == ab_step && ab_ph == 3) begin
        add(S_IDLE, 1'b0, 1'b0, '0, 1'b0, '0);
        return;
      end
      add_drain(S_P3D);
      add(S_SWAP, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    add(S_DONE, 1'b0, 1'b0, '0, 1'b0, '0);
    add(S_IDLE, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // One-step run whose phase1 or phase3 never completes, ending in ERROR.
  task automatic add_wd(input int ph);
    int                d;
    logic [N_CELL-1:0] v;
    add(S_IDLE, 1'b1, 1'b0, STEP_W'(1), 1'b0, '0);
    if (ph == 3) begin
      d = rnd_dly();
      for (int c = 0; c < d; c++) add(S_P1, 1'b0, 1'b0, '0, c == d - 1, '0);
      add_drain(S_P1D);
    end
    for (int c = 0; c < TIMEOUT; c++) begin
      v = '0;
      v[int'($urandom_range(N_CELL - 2, 0))] = 1'b1;
      if (ph == 1) add(S_P1, 1'b0, 1'b0, '0, 1'b0, '0);
      else         add(S_P3, 1'b0, 1'b0, '0, 1'b0, v);
    end
    for (int c = 0; c < 3; c++) add(S_ERR, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Inputs the sequencer must ignore in a phase are filled with random noise.
  task automatic run_plan();
    ent_t e;
    logic is_busy;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(negedge clk);
      if (e.st == S_SWAP) begin
        m_steps = m_steps + 1'b1;
        m_db    = ~m_db;
      end
      if (e.st == S_ERR) m_err = 1'b1;
      check_outputs(e.st);
      is_busy = (e.st != S_IDLE) && (e.st != S_ERR);
      start   = e.start | (is_busy & 1'($urandom_range(1, 0)));
      abort   = e.abort;
      n_steps = e.start ? e.n : STEP_W'($urandom());
      p1_done = (e.st == S_P1) ? e.p1 : 1'($urandom_range(1, 0));
      p3_done = (e.st == S_P3) ? e.p3 : N_CELL'($urandom());
      if (e.start && !e.abort && (e.st == S_IDLE || e.st == S_ERR)) begin
        m_err = 1'b0;
        if (e.n != '0) m_steps = '0;
      end
    end
  endtask

  initial begin
    int d;
    reset = 1'b0; start = 1'b0; abort = 1'b0; p1_done = 1'b0; p3_done = '0; n_steps = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(S_IDLE);
    reset = 1'b1;

    add_run(2, S_IDLE, 1, -1, 0, 1'b0);
    add_run(3, S_IDLE, 0, -1, 0, 1'b1);
    add_run(0, S_IDLE, 0, -1, 0, 1'b0);
    add_wd(1);
    add_run(1, S_ERR, 0, -1, 0, 1'b0);
    add_wd(3);
    add_run(2, S_ERR, 0, -1, 0, 1'b0);
    add_run(2, S_IDLE, TIMEOUT, -1, 0, 1'b0);
    add_run(2, S_IDLE, 0, 1, 1, 1'b0);
    add_run(3, S_IDLE, 0, 1, 3, 1'b0);
    add_run(0, S_IDLE, 0, -1, 0, 1'b0);
    run_plan();

    for (int r = 0; r < 6; r++) add_run(int'($urandom_range(4, 1)), S_IDLE, 0, -1, 0, 1'b0);
    run_plan();

    add(S_IDLE, 1'b1, 1'b0, STEP_W'(3), 1'b0, '0);
    d = rnd_dly();
    for (int c = 0; c < d; c++) add(S_P1, 1'b0, 1'b0, '0, c == d - 1, '0);
    add_drain(S_P1D);
    for (int c = 0; c < 3; c++) add(S_P3, 1'b0, 1'b0, '0, 1'b0, '0);
    run_plan();
    @(negedge clk);
    check_outputs(S_P3);
    reset = 1'b0; start = 1'b1; n_steps = STEP_W'(5); p1_done = 1'b1; p3_done = '1;
    m_db = 1'b0; m_steps = '0; m_err = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_outputs(S_IDLE);
    end
    reset = 1'b1; start = 1'b0; p1_done = 1'b0; p3_done = '0;

    add_run(1, S_IDLE, 0, -1, 0, 1'b0);
    run_plan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
